// File: rtl/sseg_port_display.sv
// sseg_port_display: port-mapped 4-digit seven-segment controller with a sequential binary-to-BCD (double-dabble) engine
// Ports: CLK, RST_N (async active-low); PORT_ID/OUT_PORT/IO_STRB CPU output bus;
//        ANODES/CATHODES active-low multiplexed display pins; BUSY high while a decimal conversion is in flight
module sseg_port_display #(
  parameter logic [7:0] DEC_PORT_ID = 8'h81,
  parameter logic [7:0] HEX_PORT_ID = 8'h82,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [3:0] ANODES,
  output logic [7:0] CATHODES,
  output logic       BUSY
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nx;
  // {hundreds, tens, ones, binary}: binary bits shift up into the BCD nibbles
  logic [19:0] sr, sr_nx, adj;
  logic [2:0] it, it_nx;
  logic [CW-1:0] rcnt;
  logic [1:0] idx;
  logic [3:0] d2, d1, d0, sel;
  logic hex_mode, dec_wr, hex_wr, blank;

  assign dec_wr = IO_STRB && PORT_ID == DEC_PORT_ID;
  assign hex_wr = IO_STRB && PORT_ID == HEX_PORT_ID;
  assign BUSY = state != IDLE;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      sr <= '0;
      it <= '0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      it <= it_nx;
    end

  always_comb begin
    adj = sr;
    adj[19:16] = sr[19:16] >= 4'd5 ? sr[19:16] + 4'd3 : sr[19:16];
    adj[15:12] = sr[15:12] >= 4'd5 ? sr[15:12] + 4'd3 : sr[15:12];
    adj[11:8] = sr[11:8] >= 4'd5 ? sr[11:8] + 4'd3 : sr[11:8];
    state_nx = state;
    sr_nx = sr;
    it_nx = it;
    if (dec_wr) begin
      state_nx = SHIFT;
      sr_nx = {12'b0, OUT_PORT};
      it_nx = '0;
    end else if (hex_wr) state_nx = IDLE;
    else if (state == SHIFT) begin
      sr_nx = {adj[18:0], 1'b0};
      it_nx = it + 3'd1;
      state_nx = it == 3'd7 ? COMMIT : SHIFT;
    end else if (state == COMMIT) state_nx = IDLE;
  end

  // a decimal write on the commit edge restarts the conversion instead of committing
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) {hex_mode, d2, d1, d0} <= '0;
    else if (hex_wr) {hex_mode, d2, d1, d0} <= {1'b1, 4'h0, OUT_PORT};
    else if (state == COMMIT && !dec_wr) {hex_mode, d2, d1, d0} <= {1'b0, sr[19:8]};

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      rcnt <= '0;
      idx <= '0;
    end else begin
      rcnt <= rcnt == LAST ? '0 : rcnt + CW'(1);
      if (rcnt == LAST) idx <= idx + 2'd1;
    end

  always_comb begin
    sel = idx == 2'd0 ? d0 : idx == 2'd1 ? d1 : d2;
    blank = idx == 2'd3 || (hex_mode ? idx == 2'd2 :
            (idx == 2'd2 && d2 == 4'd0) || (idx == 2'd1 && d2 == 4'd0 && d1 == 4'd0));
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      ANODES <= 4'hF;
      CATHODES <= 8'hFF;
    end else begin
      ANODES <= blank ? 4'hF : ~(4'b0001 << idx);
      CATHODES <= blank ? 8'hFF : GLYPH[sel];
    end
endmodule

// File: tb/tb_sseg_port_display.sv
// tb_sseg_port_display: directed plus random writes checked every cycle against an arithmetic display model
module tb_sseg_port_display;
  logic CLK = 0, RST_N = 0, IO_STRB = 0;
  logic [7:0] PORT_ID = 0, OUT_PORT = 0;
  logic [3:0] ANODES;
  logic [7:0] CATHODES;
  logic BUSY;
  int n_chk = 0, n_fail = 0;
  int n = 0, commit_at = 0, dval = 0, pval = 0;
  bit hexm = 0, pending = 0;
  logic [11:0] exp_o;
  logic [7:0] gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sseg_port_display #(.DEC_PORT_ID(8'h81), .HEX_PORT_ID(8'h82), .REFRESH_DIV(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .ANODES(ANODES), .CATHODES(CATHODES), .BUSY(BUSY));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic logic [11:0] digit_out(input int i);
    int h, t, o, dig;
    bit show;
    logic [3:0] an;
    if (hexm) begin
      show = i < 2;
      dig = i == 0 ? dval % 16 : dval / 16;
    end else begin
      h = dval / 100;
      t = (dval / 10) % 10;
      o = dval % 10;
      show = i == 0 || (i == 1 && (h != 0 || t != 0)) || (i == 2 && h != 0);
      dig = i == 0 ? o : i == 1 ? t : h;
    end
    an = 4'b0001 << i;
    return show ? {~an, gl[dig]} : 12'hFFF;
  endfunction

  task automatic model_reset();
    n = 0;
    pending = 0;
    hexm = 0;
    dval = 0;
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic s, input logic [7:0] p, input logic [7:0] d);
    IO_STRB = s;
    PORT_ID = p;
    OUT_PORT = d;
    @(posedge CLK);
    n++;
    exp_o = digit_out(((n - 1) / 4) % 4);
    if (s && p == 8'h81) begin
      pending = 1;
      pval = d;
      commit_at = n + 9;
    end else if (s && p == 8'h82) begin
      pending = 0;
      hexm = 1;
      dval = d;
    end else if (pending && n == commit_at) begin
      pending = 0;
      hexm = 0;
      dval = pval;
    end
    #1;
    chk("anodes", {4'h0, ANODES}, {4'h0, exp_o[11:8]});
    chk("cathodes", CATHODES, exp_o[7:0]);
    chk("busy", {7'h0, BUSY}, {7'h0, pending});
    @(negedge CLK);
    IO_STRB = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 8'h00, 8'h00);
  endtask

  // asserts reset between edges and checks the outputs blank before the next edge
  task automatic async_reset();
    #2 RST_N = 0;
    #1;
    chk("rst_anodes", {4'h0, ANODES}, 8'h0F);
    chk("rst_cathodes", CATHODES, 8'hFF);
    chk("rst_busy", {7'h0, BUSY}, 8'h00);
    model_reset();
    @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    int bcount, r;
    logic [7:0] pid;
    @(negedge CLK);
    @(negedge CLK);
    chk("por_anodes", {4'h0, ANODES}, 8'h0F);
    chk("por_cathodes", CATHODES, 8'hFF);
    chk("por_busy", {7'h0, BUSY}, 8'h00);
    RST_N = 1;
    idle(6);
    async_reset();
    idle(3);
    step(1, 8'h81, 8'hFF);
    bcount = BUSY;
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00, 8'h00);
      bcount += BUSY;
    end
    chk("busy_len_255", 8'(bcount), 8'd9);
    idle(16);
    step(1, 8'h81, 8'd7);
    idle(26);
    step(1, 8'h81, 8'd105);
    idle(26);
    step(1, 8'h81, 8'd200);
    idle(3);
    step(1, 8'h82, 8'h3A);
    idle(24);
    step(1, 8'h81, 8'd200);
    idle(2);
    step(1, 8'h81, 8'd9);
    idle(26);
    step(1, 8'h80, 8'h55);
    idle(18);
    step(1, 8'h81, 8'd123);
    idle(4);
    async_reset();
    idle(20);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      pid = r == 0 ? 8'h81 : r == 1 ? 8'h82 : r == 2 ? 8'h80 : 8'($urandom);
      step($urandom_range(0, 5) == 0, pid, 8'($urandom));
      if (i == 200) async_reset();
    end
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sseg_port_display.md
# sseg_port_display

Port-mapped four-digit seven-segment display controller on the RAT CPU output bus. It captures writes addressed to its port IDs, converts the byte to decimal with a sequential shift-add-3 (double-dabble) engine, and drives the board's multiplexed ANODES/CATHODES. It sits between the CPU's output-port logic and the display pins in the top-level wrapper.

## Interface
- DEC_PORT_ID, 8'h81, port ID for a decimal-mode write.
- HEX_PORT_ID, 8'h82, port ID for a hex-mode write.
- REFRESH_DIV, 100000, clock cycles each digit is held; must be ≥2.

- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low.
- PORT_ID  in  8  CPU output port address.
- OUT_PORT  in  8  CPU output data.
- IO_STRB  in  1  write strobe; one-cycle pulse, sampled on CLK.
- ANODES  out  4  digit enables, active low; bit 0 is the rightmost digit.
- CATHODES  out  8  segments, active low, {dp,g,f,e,d,c,b,a}.
- BUSY  out  1  high while a decimal conversion is in flight.

## Operation
- Write: at any edge with IO_STRB=1 and PORT_ID=DEC_PORT_ID or HEX_PORT_ID, OUT_PORT is captured. Other PORT_IDs are ignored.
- Conversion FSM states are IDLE, SHIFT and COMMIT.
  - A decimal write in any state loads the shift register with {12'b0, OUT_PORT}, clears the iteration count and enters SHIFT. An in-flight conversion is aborted; the last write wins.
  - SHIFT runs 8 iterations, one per cycle. Each iteration adds 3 to any BCD nibble ≥5, then shifts left by 1. After the 8th iteration the FSM goes to COMMIT.
  - COMMIT loads the hundreds, tens and ones nibbles into the display registers, sets mode=decimal, and returns to IDLE.
- A hex write in any state aborts any conversion and goes directly to IDLE. On the same edge it loads the display nibbles {0,0,OUT_PORT[7:4],OUT_PORT[3:0]} and sets mode=hex.
- A decimal write and a hex write cannot occur on the same edge, because there is a single PORT_ID.
- Blanking, decimal mode:
  - Digit 3 is always blank.
  - Digit 2 is blank if hundreds=0.
  - Digit 1 is blank if hundreds=0 and tens=0.
  - Digit 0 is never blank.
- Blanking, hex mode: digits 0 and 1 are shown; digits 2 and 3 are blank.
- Scanning:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - The digit index (0..3, wrapping 3→0) advances on the edge where the counter equals REFRESH_DIV-1.
- Output register, loaded every edge from the current index and display registers:
  - Selected digit not blank: ANODES is low only at the index bit, and CATHODES holds the glyph.
  - Selected digit blank: ANODES=4'hF and CATHODES=8'hFF.
- Glyphs (the dp bit is always 1):
  - 0..4 = C0 F9 A4 B0 99
  - 5..9 = 92 82 F8 80 90
  - A..F = 88 83 C6 A1 86 8E

## Timing
- Reset (asynchronous, while RST_N=0):
  - ANODES=4'hF, CATHODES=8'hFF, BUSY=0.
  - FSM=IDLE; counter, index and display nibbles = 0; mode=decimal.
- First edge after release: ANODES=4'b1110, CATHODES=8'hC0 (shows "0").
- Decimal write captured at edge k:
  - BUSY=1 from k through k+8.
  - Iterations run on edges k+1..k+8; commit happens at k+9, and BUSY=0 after k+9.
  - A new decimal write at edge j during the conversion restarts it, so the commit moves to j+9.
- Hex write at edge k: display nibbles update at k; the output register reflects them at k+1 if that digit is selected.
- Output latency: ANODES/CATHODES lag the index and display registers by exactly one cycle.
- A display-register update never alters the refresh counter or the digit index.
- RST_N asserted mid-conversion: the conversion is discarded and the outputs blank immediately.

## Test plan
Run all scenarios with REFRESH_DIV=4.
- Reset mid-scan and mid-conversion: drive RST_N=0 asynchronously between edges -> ANODES=F and CATHODES=FF before the next edge, BUSY=0. After release, digit 0 shows C0.
- Decimal write 8'hFF -> BUSY high for 9 edges. Then scan shows digit0=92 (5), digit1=92 (5), digit2=A4 (2); during digit 3's slot ANODES=F, CATHODES=FF.
- Decimal write 8'd7 -> only the digit-0 slot is lit (CATHODES=F8); the slots for digits 1-3 give ANODES=F. Decimal write 8'd105 -> digit1=C0 (the internal zero is shown) and digit2=F9.
- Hex write 8'h3A at edge k during a decimal conversion of 200 -> BUSY drops and "200" never appears. digit0=88 and digit1=B0 from k+1 onward; digits 2 and 3 are blank.
- Back-to-back decimal writes, 200 at k then 9 at k+3 -> the commit happens at k+12 with only digit0=90 lit. IO_STRB with PORT_ID=8'h80 and OUT_PORT=8'h55 -> the display and BUSY are unchanged.
